// File: rtl/window_3x3_generator.sv
// 3x3 neighbourhood producer: two line buffers plus three shifting window rows fed from a DVI-style stream.
// Syncs and the raw pixel are re-timed by one clock so they line up with the window outputs.
module window_3x3_generator #(
    parameter int DATA_W   = 24,
    parameter int H_ACTIVE = 1280,
    parameter int COL_W    = 11
) (
    input  logic              in_Pixel_Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] in_Data,
    input  logic              in_HSync,
    input  logic              in_VSync,
    input  logic              in_VDE,
    output logic [DATA_W-1:0] out_M1 [3],
    output logic [DATA_W-1:0] out_M2 [3],
    output logic [DATA_W-1:0] out_M3 [3],
    output logic              out_Ready,
    output logic [DATA_W-1:0] out_preProcess,
    output logic              out_HSync,
    output logic              out_VSync,
    output logic              out_VDE,
    output logic              out_Pixel_Clk
);

    localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] COL_ZERO = COL_W'(0);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

    typedef enum logic [1:0] {
        S_WAIT_FRAME = 2'd0,
        S_BLANK      = 2'd1,
        S_LINE       = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [DATA_W-1:0] m1_q [3];
    logic [DATA_W-1:0] m2_q [3];
    logic [DATA_W-1:0] m3_q [3];
    logic [DATA_W-1:0] m1_d [3];
    logic [DATA_W-1:0] m2_d [3];
    logic [DATA_W-1:0] m3_d [3];
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] pre_q, pre_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              vde_q, vde_d;

    logic [DATA_W-1:0] lb0_q [H_ACTIVE];
    logic [DATA_W-1:0] lb1_q [H_ACTIVE];

    logic              vs_edge_s;
    logic              take_s;
    logic              process_s;
    logic [COL_W-1:0]  pix_col_s;
    logic [COL_W-1:0]  col_inc_s;
    logic [AW-1:0]     lb_idx_s;
    logic [DATA_W-1:0] lb0_rd_s;
    logic [DATA_W-1:0] lb1_rd_s;

    assign vs_edge_s = in_VSync & ~vsync_q;
    assign col_inc_s = (col_q == COL_MAX) ? COL_MAX : col_q + COL_ONE;

    // Frame/line tracking: next state, row and column, and which column the current pixel lands in.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        pix_col_s = col_q;
        take_s    = 1'b0;
        case (state_q)
            S_WAIT_FRAME: begin
                if (vs_edge_s) begin
                    state_d = S_BLANK;
                    row_d   = 2'd0;
                    col_d   = COL_ZERO;
                end else begin
                    state_d = S_WAIT_FRAME;
                end
            end
            S_BLANK: begin
                if (vs_edge_s) begin
                    row_d = 2'd0;
                    col_d = COL_ZERO;
                end else if (in_VDE) begin
                    state_d   = S_LINE;
                    pix_col_s = COL_ZERO;
                    take_s    = 1'b1;
                    col_d     = COL_ONE;
                end else begin
                    state_d = S_BLANK;
                end
            end
            S_LINE: begin
                if (vs_edge_s) begin
                    state_d = S_BLANK;
                    row_d   = 2'd0;
                    col_d   = COL_ZERO;
                end else if (in_VDE) begin
                    take_s = 1'b1;
                    col_d  = col_inc_s;
                end else begin
                    state_d = S_BLANK;
                    col_d   = COL_ZERO;
                    row_d   = (row_q == 2'd3) ? 2'd3 : row_q + 2'd1;
                end
            end
            default: begin
                state_d = S_WAIT_FRAME;
                row_d   = 2'd0;
                col_d   = COL_ZERO;
            end
        endcase
    end

    assign process_s = take_s && (pix_col_s < COL_MAX);
    assign lb_idx_s  = pix_col_s[AW-1:0];
    assign lb0_rd_s  = lb0_q[lb_idx_s];
    assign lb1_rd_s  = lb1_q[lb_idx_s];

    // Window shift, ready qualifier and one-cycle re-timing of the pass-through signals.
    always_comb begin
        m1_d    = m1_q;
        m2_d    = m2_q;
        m3_d    = m3_q;
        ready_d = 1'b0;
        pre_d   = in_Data;
        hsync_d = in_HSync;
        vsync_d = in_VSync;
        vde_d   = in_VDE;
        if (process_s) begin
            m1_d[0] = m1_q[1];
            m1_d[1] = m1_q[2];
            m1_d[2] = lb1_rd_s;
            m2_d[0] = m2_q[1];
            m2_d[1] = m2_q[2];
            m2_d[2] = lb0_rd_s;
            m3_d[0] = m3_q[1];
            m3_d[1] = m3_q[2];
            m3_d[2] = in_Data;
            // Rows 0-1 may still see the previous frame in the buffers, so they never qualify.
            ready_d = (row_q >= 2'd2) && (pix_col_s >= COL_TWO);
        end else begin
            m1_d    = m1_q;
            m2_d    = m2_q;
            m3_d    = m3_q;
            ready_d = 1'b0;
        end
    end

    // Control and window registers with asynchronous reset.
    always_ff @(posedge in_Pixel_Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_WAIT_FRAME;
            row_q   <= 2'd0;
            col_q   <= COL_ZERO;
            m1_q    <= '{default: '0};
            m2_q    <= '{default: '0};
            m3_q    <= '{default: '0};
            ready_q <= 1'b0;
            pre_q   <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            vde_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            m3_q    <= m3_d;
            ready_q <= ready_d;
            pre_q   <= pre_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            vde_q   <= vde_d;
        end
    end

    // Line buffers: lb1 takes the old lb0 entry while lb0 takes the new pixel (storage is not reset).
    always_ff @(posedge in_Pixel_Clk) begin
        if (process_s) begin
            lb1_q[lb_idx_s] <= lb0_rd_s;
            lb0_q[lb_idx_s] <= in_Data;
        end
    end

    assign out_M1         = m1_q;
    assign out_M2         = m2_q;
    assign out_M3         = m3_q;
    assign out_Ready      = ready_q;
    assign out_preProcess = pre_q;
    assign out_HSync      = hsync_q;
    assign out_VSync      = vsync_q;
    assign out_VDE        = vde_q;
    assign out_Pixel_Clk  = in_Pixel_Clk;

endmodule

// File: tb/tb_window_3x3_generator.sv
// Scoreboard bench for window_3x3_generator at H_ACTIVE=4, 8-bit pixels valued base + row*16 + col.
module tb_window_3x3_generator;

    localparam int DW = 8;

    logic          clk;
    logic          Reset;
    logic [DW-1:0] in_Data;
    logic          in_HSync, in_VSync, in_VDE;
    logic [DW-1:0] out_M1 [3];
    logic [DW-1:0] out_M2 [3];
    logic [DW-1:0] out_M3 [3];
    logic          out_Ready;
    logic [DW-1:0] out_preProcess;
    logic          out_HSync, out_VSync, out_VDE, out_Pixel_Clk;

    int total = 0;
    int bad   = 0;
    int ready_cnt = 0;
    int rc0;
    logic [71:0] exp_q [$];
    logic [71:0] got_w, exp_w;

    logic [DW-1:0] prev_data;
    logic          prev_hs, prev_vs, prev_vde;

    window_3x3_generator #(.DATA_W(DW), .H_ACTIVE(4), .COL_W(3)) dut (
        .in_Pixel_Clk  (clk),
        .Reset         (Reset),
        .in_Data       (in_Data),
        .in_HSync      (in_HSync),
        .in_VSync      (in_VSync),
        .in_VDE        (in_VDE),
        .out_M1        (out_M1),
        .out_M2        (out_M2),
        .out_M3        (out_M3),
        .out_Ready     (out_Ready),
        .out_preProcess(out_preProcess),
        .out_HSync     (out_HSync),
        .out_VSync     (out_VSync),
        .out_VDE       (out_VDE),
        .out_Pixel_Clk (out_Pixel_Clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] pv(input logic [7:0] b, input int r, input int c);
        return b + 8'(r * 16 + c);
    endfunction

    // Reference for the one-cycle pass-through delay.
    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            prev_data <= '0;
            prev_hs   <= 1'b0;
            prev_vs   <= 1'b0;
            prev_vde  <= 1'b0;
        end else begin
            prev_data <= in_Data;
            prev_hs   <= in_HSync;
            prev_vs   <= in_VSync;
            prev_vde  <= in_VDE;
        end
    end

    // Monitor: checks delayed signals every cycle and pops one expected window per out_Ready.
    always @(negedge clk) begin
        if (!Reset) begin
            chk("hsync_delay", 72'(out_HSync), 72'(prev_hs));
            chk("vsync_delay", 72'(out_VSync), 72'(prev_vs));
            chk("vde_delay", 72'(out_VDE), 72'(prev_vde));
            chk("preprocess_delay", 72'(out_preProcess), 72'(prev_data));
            if (out_Ready) begin
                ready_cnt++;
                got_w = {out_M1[0], out_M1[1], out_M1[2], out_M2[0], out_M2[1], out_M2[2],
                         out_M3[0], out_M3[1], out_M3[2]};
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 72'(1), 72'(0));
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("window", got_w, exp_w);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input logic [7:0] base, input int r, input int npix, input bit push);
        for (int c = 0; c < npix; c++) begin
            in_VDE  = 1'b1;
            in_Data = pv(base, r, c);
            if (push && r >= 2 && c >= 2 && c < 4)
                exp_q.push_back({pv(base, r-2, c-2), pv(base, r-2, c-1), pv(base, r-2, c),
                                 pv(base, r-1, c-2), pv(base, r-1, c-1), pv(base, r-1, c),
                                 pv(base, r,   c-2), pv(base, r,   c-1), pv(base, r,   c)});
            cyc();
        end
    endtask

    task automatic blank();
        in_VDE   = 1'b0;
        in_HSync = 1'b1;
        cyc();
        in_HSync = 1'b0;
        cyc();
    endtask

    task automatic vsync_pulse();
        in_VDE   = 1'b0;
        in_VSync = 1'b1;
        cyc();
        cyc();
        in_VSync = 1'b0;
        blank();
    endtask

    task automatic frame(input logic [7:0] base, input int nlines, input int npix);
        for (int r = 0; r < nlines; r++) begin
            drive_line(base, r, npix, 1'b1);
            blank();
        end
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; in_Data = '0; in_HSync = 1'b0; in_VSync = 1'b0; in_VDE = 1'b0;
        repeat (3) cyc();
        chk("rst_ready", 72'(out_Ready), 72'(0));
        chk("rst_m1", 72'(out_M1[0]), 72'(0));
        chk("rst_m2", 72'(out_M2[1]), 72'(0));
        chk("rst_m3", 72'(out_M3[2]), 72'(0));
        chk("rst_pre", 72'(out_preProcess), 72'(0));
        chk("rst_vde", 72'(out_VDE), 72'(0));
        chk("pixclk_pass", 72'(out_Pixel_Clk), 72'(clk));
        Reset = 1'b0;
        cyc();

        // Basic frame.
        rc0 = ready_cnt;
        vsync_pulse();
        frame(8'h00, 4, 4);
        blank();
        chk("s1_ready_count", 72'(ready_cnt - rc0), 72'(4));
        chk("s1_queue_empty", 72'(exp_q.size()), 72'(0));

        // Lines before any VSync are ignored.
        pulse_reset();
        rc0 = ready_cnt;
        drive_line(8'hE0, 0, 4, 1'b0); blank();
        drive_line(8'hE0, 1, 4, 1'b0); blank();
        chk("s2_prevsync_ready", 72'(ready_cnt - rc0), 72'(0));
        vsync_pulse();
        frame(8'h00, 4, 4);
        blank();
        chk("s2_ready_count", 72'(ready_cnt - rc0), 72'(4));
        chk("s2_queue_empty", 72'(exp_q.size()), 72'(0));

        // Over-long lines: columns 4-5 neither write nor shift.
        rc0 = ready_cnt;
        vsync_pulse();
        drive_line(8'h40, 0, 6, 1'b1); blank();
        drive_line(8'h40, 1, 6, 1'b1); blank();
        drive_line(8'h40, 2, 6, 1'b1);
        chk("s3_hold_m3_0", 72'(out_M3[0]), 72'(8'h61));
        chk("s3_hold_m3_2", 72'(out_M3[2]), 72'(8'h63));
        chk("s3_hold_m1_2", 72'(out_M1[2]), 72'(8'h43));
        chk("s3_ready_low", 72'(out_Ready), 72'(0));
        blank();
        chk("s3_ready_count", 72'(ready_cnt - rc0), 72'(2));
        chk("s3_queue_empty", 72'(exp_q.size()), 72'(0));

        // Async reset in row 3 col 1.
        vsync_pulse();
        drive_line(8'h00, 0, 4, 1'b1); blank();
        drive_line(8'h00, 1, 4, 1'b1); blank();
        drive_line(8'h00, 2, 4, 1'b1); blank();
        drive_line(8'h00, 3, 2, 1'b1);
        #1 Reset = 1'b1;
        #1;
        chk("s4_rst_ready", 72'(out_Ready), 72'(0));
        chk("s4_rst_m3", 72'(out_M3[2]), 72'(0));
        chk("s4_rst_m1", 72'(out_M1[2]), 72'(0));
        chk("s4_rst_pre", 72'(out_preProcess), 72'(0));
        chk("s4_rst_vde", 72'(out_VDE), 72'(0));
        in_VDE = 1'b0;
        cyc();
        Reset = 1'b0;
        cyc();
        rc0 = ready_cnt;
        for (int r = 0; r < 3; r++) begin
            drive_line(8'hC0, r, 4, 1'b0);
            blank();
        end
        chk("s4_ignored_ready", 72'(ready_cnt - rc0), 72'(0));
        vsync_pulse();
        frame(8'hA0, 4, 4);
        blank();
        chk("s4_ready_count", 72'(ready_cnt - rc0), 72'(4));
        chk("s4_queue_empty", 72'(exp_q.size()), 72'(0));

        // Back-to-back frames.
        rc0 = ready_cnt;
        vsync_pulse();
        frame(8'h00, 4, 4);
        vsync_pulse();
        frame(8'h80, 4, 4);
        blank();
        chk("s5_ready_count", 72'(ready_cnt - rc0), 72'(8));
        chk("s5_queue_empty", 72'(exp_q.size()), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
